// File: rtl/noc_pkg.sv
// Shared flit framing types and widths for the NoC router port logic.
package noc_pkg;

  localparam int unsigned FLIT_W = 16;
  localparam int unsigned FT_W   = 2;

  typedef enum logic [FT_W-1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef struct packed {
    flit_type_e              ftype;
    logic [FLIT_W-FT_W-1:0]  payload;
  } flit_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_PACKET = 1'b1
  } outport_state_e;

endpackage

// File: rtl/noc_output_port_credit.sv
// Credit counter mirroring the downstream buffer occupancy; saturates at MAX.
module noc_credit_counter #(
  parameter int unsigned INIT = 5,
  parameter int unsigned MAX  = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inc,
  input  logic                       dec,
  output logic [$clog2(MAX+1)-1:0]   count,
  output logic                       overflow_c
);

  localparam int unsigned CW = $clog2(MAX + 1);

  // A return at MAX without a matching consume has nowhere to go.
  assign overflow_c = inc && !dec && (count == CW'(MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= CW'(INIT);
    end else if (inc && !dec && (count != CW'(MAX))) begin
      count <= count + CW'(1);
    end else if (dec && !inc) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/noc_output_port.sv
// Router output port: skid FIFO, credit-gated link push and packet framing tracker.
// Optional NOC_OUTPORT_STATS_EN adds flit_cnt_o / stall_cnt_o counters.
module noc_output_port
  import noc_pkg::*;
#(
  parameter int unsigned WIDTH     = FLIT_W,
  parameter int unsigned CREDITS   = 5,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              data_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  output logic [WIDTH-1:0]              data_o,
  output logic                          write_en_o,
  input  logic                          credit_i,
  output logic                          pkt_active_o,
  output logic [$clog2(CREDITS+1)-1:0]  credits_o,
  output logic                          error_o
`ifdef NOC_OUTPORT_STATS_EN
  ,
  output logic [31:0]                   flit_cnt_o,
  output logic [31:0]                   stall_cnt_o
`endif
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned NW = $clog2(BUF_DEPTH + 1);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [NW-1:0]    count;
  logic             accept, send, credit_ovf_c, fsm_err;
  flit_type_e       in_type;
  outport_state_e   state, next_state;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ready uses the pre-pop count, so a full FIFO never takes a flit.
  assign ready_o = !rst && (count != NW'(BUF_DEPTH));
  assign accept  = valid_i && ready_o;
  assign send    = (count != '0) && (credits_o != '0);
  assign in_type = flit_type_e'(data_i[WIDTH-1 -: FT_W]);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (send)   rd_ptr <= ptr_inc(rd_ptr);
      count <= count + NW'(accept) - NW'(send);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= data_i;
  end

  // Link side: data_o holds the last flit between pushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en_o <= 1'b0;
      data_o     <= '0;
    end else begin
      write_en_o <= send;
      if (send) data_o <= mem[rd_ptr];
    end
  end

  noc_credit_counter #(
    .INIT (CREDITS),
    .MAX  (CREDITS)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .inc        (credit_i),
    .dec        (send),
    .count      (credits_o),
    .overflow_c (credit_ovf_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Framing tracks accepted flits; bad framing flags an error but the flit is kept.
  always_comb begin
    next_state = state;
    fsm_err    = 1'b0;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (in_type == FT_HEAD)        next_state = ST_PACKET;
          else if (in_type != FT_SINGLE) fsm_err    = 1'b1;
        end
        ST_PACKET: begin
          if (in_type == FT_TAIL)        next_state = ST_IDLE;
          else if (in_type != FT_BODY)   fsm_err    = 1'b1;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  assign pkt_active_o = (state == ST_PACKET);

  always_ff @(posedge clk) begin
    if (rst)                             error_o <= 1'b0;
    else if (fsm_err || credit_ovf_c)    error_o <= 1'b1;
  end

`ifdef NOC_OUTPORT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (send) flit_cnt_o <= flit_cnt_o + 32'd1;
      if ((count != '0) && (credits_o == '0)) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule
